// File: rtl/rst_sequencer_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package rst_sequencer_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_DONE    = 3'd3,
    ST_SOFT    = 3'd4
  } rst_seq_state_t;

  // Larger of two integers; sizes the shared hold/step counter.
  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Soft-reset handshake and staged reset outputs of the reset sequencer.
// master: the requester / reset consumer side; slave: the sequencer.
interface rst_sequencer_if #(
  parameter int NUM_OUT = 3
);
  logic               soft_rst_req;
  logic               soft_rst_ack;
  logic [NUM_OUT-1:0] rst_out_n;
  logic               seq_done;

  modport master (
    output soft_rst_req,
    input  soft_rst_ack,
    input  rst_out_n,
    input  seq_done
  );

  modport slave (
    input  soft_rst_req,
    output soft_rst_ack,
    output rst_out_n,
    output seq_done
  );
endinterface

// File: rtl/rst_sequencer_rst_sync.sv
// Asynchronous-assert / synchronous-deassert reset flop chain.
module rst_sync #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);
  localparam logic [STAGES-1:0] ONE = STAGES'(1);

  logic [STAGES-1:0] chain_r;

  // Shift ones in after reset release; clear the whole chain asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= (chain_r << 1) | ONE;
    end
  end

  assign sync_rst_n = chain_r[STAGES-1];
endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: async assertion, synchronized release of the
// block resets in index order, and a four-phase soft-reset handshake.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int NUM_OUT     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 4,
  parameter int STEP_DLY    = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  rst_sequencer_if.slave  bus
);
  localparam int CNT_W = $clog2(max(HOLD_CYC, STEP_DLY) + 1);
  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OUT - 1);

  if (NUM_OUT < 1)     begin : g_bad_num   $fatal(1, "rst_sequencer: NUM_OUT must be >= 1");     end
  if (SYNC_STAGES < 2) begin : g_bad_sync  $fatal(1, "rst_sequencer: SYNC_STAGES must be >= 2"); end
  if (HOLD_CYC < 1)    begin : g_bad_hold  $fatal(1, "rst_sequencer: HOLD_CYC must be >= 1");    end
  if (STEP_DLY < 1)    begin : g_bad_step  $fatal(1, "rst_sequencer: STEP_DLY must be >= 1");    end

  rst_seq_state_t     state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [NUM_OUT-1:0] rst_out_n_r, rst_out_n_s;
  logic               seq_done_r, seq_done_s;
  logic               ack_r, ack_s;
  logic               sync_rst_n_s;

  // The FSM state register is the final synchronizer stage, so the chain
  // itself is one flop shorter than SYNC_STAGES.
  rst_sync #(.STAGES(SYNC_STAGES - 1)) u_sync (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .sync_rst_n (sync_rst_n_s)
  );

  // State, counter, index and all outputs; everything asserts asynchronously.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r     <= ST_SYNC;
      cnt_r       <= CNT_ZERO;
      idx_r       <= '0;
      rst_out_n_r <= '0;
      seq_done_r  <= 1'b0;
      ack_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      rst_out_n_r <= rst_out_n_s;
      seq_done_r  <= seq_done_s;
      ack_r       <= ack_s;
    end
  end

  // Next-state and next-output logic; counter reloads on each state entry
  // and only decrements while non-zero.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    rst_out_n_s = rst_out_n_r;
    seq_done_s  = seq_done_r;
    ack_s       = ack_r;
    case (state_r)
      ST_SYNC: begin
        if (sync_rst_n_s) begin
          state_s = ST_HOLD;
          cnt_s   = HOLD_LOAD;
          idx_s   = '0;
        end else begin
          state_s = ST_SYNC;
        end
      end
      ST_HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          rst_out_n_s[0] = 1'b1;
          if (NUM_OUT == 1) begin
            state_s    = ST_DONE;
            seq_done_s = 1'b1;
            cnt_s      = CNT_ZERO;
          end else begin
            state_s = ST_RELEASE;
            cnt_s   = STEP_LOAD;
            idx_s   = IDX_W'(1);
          end
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_r == CNT_ZERO) begin
          rst_out_n_s[idx_r] = 1'b1;
          if (idx_r == LAST_IDX) begin
            state_s    = ST_DONE;
            seq_done_s = 1'b1;
            cnt_s      = CNT_ZERO;
          end else begin
            idx_s = idx_r + IDX_W'(1);
            cnt_s = STEP_LOAD;
          end
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.soft_rst_req) begin
          state_s     = ST_SOFT;
          rst_out_n_s = '0;
          seq_done_s  = 1'b0;
          ack_s       = 1'b1;
          cnt_s       = CNT_ZERO;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_SOFT: begin
        if (!bus.soft_rst_req) begin
          state_s = ST_HOLD;
          ack_s   = 1'b0;
          cnt_s   = HOLD_LOAD;
          idx_s   = '0;
        end else begin
          state_s = ST_SOFT;
        end
      end
      default: begin
        state_s     = ST_SYNC;
        cnt_s       = CNT_ZERO;
        idx_s       = '0;
        rst_out_n_s = '0;
        seq_done_s  = 1'b0;
        ack_s       = 1'b0;
      end
    endcase
  end

  assign bus.rst_out_n    = rst_out_n_r;
  assign bus.seq_done     = seq_done_r;
  assign bus.soft_rst_ack = ack_r;
endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: default instance plus a
// NUM_OUT=1 / HOLD_CYC=1 instance sharing clock and reset.
module tb_rst_sequencer;
  logic sys_clk;
  logic sys_rst_n;
  int   edge_cnt;
  int   pass_cnt;
  int   total_cnt;

  rst_sequencer_if #(.NUM_OUT(3)) bus0 ();
  rst_sequencer_if #(.NUM_OUT(1)) bus1 ();

  assign bus1.soft_rst_req = 1'b0;

  rst_sequencer #(.NUM_OUT(3), .SYNC_STAGES(2), .HOLD_CYC(4), .STEP_DLY(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus0)
  );

  rst_sequencer #(.NUM_OUT(1), .SYNC_STAGES(2), .HOLD_CYC(1), .STEP_DLY(8)) dut1 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus1)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int       edge_n;
    logic [2:0] out;
    logic     done;
    logic     ack;
    logic     out1;
    logic     done1;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [2:0] out, input logic done, input logic ack);
    check({tag, ".rst_out_n"}, 8'(bus0.rst_out_n), 8'(out));
    check({tag, ".seq_done"}, 8'(bus0.seq_done), 8'(done));
    check({tag, ".ack"}, 8'(bus0.soft_rst_ack), 8'(ack));
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    edge_cnt++;
  endtask

  task automatic run_to(input int target);
    while (edge_cnt < target) step();
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    repeat (5) step();
    check_main("in_reset", 3'b000, 1'b0, 1'b0);
    check("in_reset.out1", 8'(bus1.rst_out_n), 8'h00);
    sys_rst_n = 1'b1;
    edge_cnt  = 0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 10; i++) begin
      run_to(vecs[i].edge_n);
      check_main(tag, vecs[i].out, vecs[i].done, vecs[i].ack);
      check({tag, ".out1"}, 8'(bus1.rst_out_n), 8'(vecs[i].out1));
      check({tag, ".done1"}, 8'(bus1.seq_done), 8'(vecs[i].done1));
    end
  endtask

  initial begin
    int e;
    pass_cnt  = 0;
    total_cnt = 0;
    edge_cnt  = 0;
    sys_rst_n = 1'b0;
    bus0.soft_rst_req = 1'b0;

    vecs[0] = '{1,  3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2,  3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{3,  3'b000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{5,  3'b000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{6,  3'b001, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{13, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{14, 3'b011, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{21, 3'b011, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{22, 3'b111, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{30, 3'b111, 1'b1, 1'b0, 1'b1, 1'b1};

    #1;
    check_main("por_t0", 3'b000, 1'b0, 1'b0);

    // Power-on sequence
    apply_reset();
    run_table("por");

    // Soft reset handshake from ST_DONE
    bus0.soft_rst_req = 1'b1;
    e = edge_cnt + 1;
    run_to(e);
    check_main("soft_E", 3'b000, 1'b0, 1'b1);
    run_to(e + 2);
    check_main("soft_E2", 3'b000, 1'b0, 1'b1);
    bus0.soft_rst_req = 1'b0;
    run_to(e + 3);
    check_main("soft_E3", 3'b000, 1'b0, 1'b0);
    run_to(e + 6);
    check_main("soft_E6", 3'b000, 1'b0, 1'b0);
    run_to(e + 7);
    check_main("soft_E7", 3'b001, 1'b0, 1'b0);
    run_to(e + 14);
    check_main("soft_E14", 3'b001, 1'b0, 1'b0);
    run_to(e + 15);
    check_main("soft_E15", 3'b011, 1'b0, 1'b0);
    run_to(e + 22);
    check_main("soft_E22", 3'b011, 1'b0, 1'b0);
    run_to(e + 23);
    check_main("soft_E23", 3'b111, 1'b1, 1'b0);

    // Mid-sequence reset between edges 10 and 11
    apply_reset();
    run_to(10);
    check_main("mid_e10", 3'b001, 1'b0, 1'b0);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check_main("mid_async", 3'b000, 1'b0, 1'b0);
    check("mid_async.out1", 8'(bus1.rst_out_n), 8'h00);
    check("mid_async.done1", 8'(bus1.seq_done), 8'h00);
    step();
    step();
    sys_rst_n = 1'b1;
    edge_cnt  = 0;
    run_table("mid");

    // Early soft request held from edge 8
    apply_reset();
    run_to(7);
    bus0.soft_rst_req = 1'b1;
    run_to(8);
    check_main("early_e8", 3'b001, 1'b0, 1'b0);
    run_to(21);
    check_main("early_e21", 3'b011, 1'b0, 1'b0);
    run_to(22);
    check_main("early_e22", 3'b111, 1'b1, 1'b0);
    run_to(23);
    check_main("early_e23", 3'b000, 1'b0, 1'b1);
    bus0.soft_rst_req = 1'b0;
    run_to(24);
    check_main("early_e24", 3'b000, 1'b0, 1'b0);

    // Short reset glitch in ST_DONE
    apply_reset();
    run_to(25);
    check_main("glitch_pre", 3'b111, 1'b1, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_main("glitch_low", 3'b000, 1'b0, 1'b0);
    check("glitch_low.out1", 8'(bus1.rst_out_n), 8'h00);
    #2;
    sys_rst_n = 1'b1;
    edge_cnt  = 0;
    run_table("glitch");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
